// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction fetch front end. A PC register addresses a combinational
// instruction memory; each fetched word is pushed with its PC into a small
// FIFO that the consumer drains with a valid/ready handshake. Redirects
// flush the FIFO and reload the PC; halt stops new fetches but lets the
// FIFO drain.
//
// Optional feature (macro FETCH_BOUNDS_CHECK_EN):
//   defined   - a PC whose word would extend past MEM_BYTES stops fetch and
//               raises fault until a redirect or reset.
//   undefined - the PC lives modulo MEM_BYTES and fault is tied low.
//
// Parameters
//   MEM_BYTES      instruction memory size in bytes (power of two, > 4)
//   QDEPTH         fetch queue entries (power of two, >= 2)
//   RESET_PC       word-aligned byte address fetched first after reset
//
// Ports
//   clk            clock, all state on rising edge
//   reset          synchronous active-high reset
//   imem_addr      byte address to instruction memory (word aligned)
//   imem_instr     instruction at imem_addr, same cycle
//   redirect_valid branch/flush request (highest priority after reset)
//   redirect_pc    new fetch byte address, bits [1:0] ignored
//   halt           blocks new fetches while high
//   out_valid      queue head valid
//   out_ready      consumer accepts head
//   out_instr      head instruction
//   out_pc         head byte address
//   q_count        queue occupancy
//   fault          fetch stopped on an out-of-bounds PC
//
// States
//   state  | meaning
//   RUN    | fetching one word per cycle when the queue has room
//   HALTED | halt seen; no fetches, queue drains
//   FAULT  | PC out of bounds; no fetches, queue drains, fault asserted
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int          MEM_BYTES = 1024,
    parameter int          QDEPTH    = 4,
    parameter logic [63:0] RESET_PC  = 64'd0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [63:0]               imem_addr,
    input  logic [31:0]               imem_instr,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    input  logic                      halt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_instr,
    output logic [63:0]               out_pc,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      fault
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [63:0]       pc;
    logic [63:0]       pc_inc;
    logic [63:0]       redirect_target;
    logic [63:0]       reset_addr;
    logic              out_of_bounds;

    logic [63:0]       q_pc    [QDEPTH];
    logic [31:0]       q_instr [QDEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              deq;
    logic              enq;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [63:0] LAST_WORD = 64'(MEM_BYTES - 4);

    // Compare against the last legal word address rather than PC+3 so a PC
    // near 2^64 cannot wrap and look in-bounds.
    assign out_of_bounds   = (pc > LAST_WORD);
    assign pc_inc          = pc + 64'd4;
    assign redirect_target = {redirect_pc[63:2], 2'b00};
    assign reset_addr      = {RESET_PC[63:2], 2'b00};
    assign fault           = (state == FAULT);
`else
    localparam logic [63:0] ADDR_MASK = 64'(MEM_BYTES - 1);

    // Power-of-two memory: masking gives the modulo wrap for free.
    assign out_of_bounds   = 1'b0;
    assign pc_inc          = (pc + 64'd4) & ADDR_MASK;
    assign redirect_target = {redirect_pc[63:2], 2'b00} & ADDR_MASK;
    assign reset_addr      = {RESET_PC[63:2], 2'b00} & ADDR_MASK;
    assign fault           = 1'b0;
`endif

    // A redirect discards any pop in the same cycle, so the head entry is
    // not considered consumed.
    assign deq = (count != '0) && out_ready && !redirect_valid;

    // A full queue can still accept a fetch when the head leaves this cycle.
    assign enq = (state == RUN) && !halt && !redirect_valid && !out_of_bounds &&
                 ((count != FULL_CNT) || deq);

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = halt ? HALTED : RUN;
        end else begin
            case (state)
                RUN: begin
                    if (halt) begin
                        state_next = HALTED;
                    end else if (out_of_bounds) begin
                        state_next = FAULT;
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        state_next = RUN;
                    end
                end
                FAULT: begin
                    state_next = FAULT;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= reset_addr;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                pc    <= redirect_target;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq) begin
                    pc   <= pc_inc;
                    tail <= tail + PTR_W'(1);
                end
                if (deq) begin
                    head <= head + PTR_W'(1);
                end
                case ({enq, deq})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only read while count != 0.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc[tail]    <= pc;
            q_instr[tail] <= imem_instr;
        end
    end

    assign imem_addr = pc;
    assign out_valid = (count != '0);
    assign out_pc    = q_pc[head];
    assign out_instr = q_instr[head];
    assign q_count   = count;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam int MEM_BYTES = 1024;
    localparam int QDEPTH    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  q_count;
    logic        fault;

    always #5 clk = ~clk;

    // Memory word i holds the value i.
    assign imem_instr = imem_addr[33:2];

    fetch_ctrl #(
        .MEM_BYTES (MEM_BYTES),
        .QDEPTH    (QDEPTH),
        .RESET_PC  (64'd0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .q_count        (q_count),
        .fault          (fault)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: fetch queue as a list of PCs, plus "stopped" flags.
    logic [63:0] m_pc;
    logic [63:0] m_q[$];
    bit          m_halted;
    bit          m_faulted;

    function automatic logic [31:0] mem_word(logic [63:0] a);
        return 32'(a / 4);
    endfunction

    function automatic logic [63:0] norm_pc(logic [63:0] a);
`ifdef FETCH_BOUNDS_CHECK_EN
        return a - (a % 4);
`else
        return (a - (a % 4)) % 64'(MEM_BYTES);
`endif
    endfunction

    function automatic logic [63:0] next_pc(logic [63:0] a);
`ifdef FETCH_BOUNDS_CHECK_EN
        return a + 4;
`else
        return (a + 4) % 64'(MEM_BYTES);
`endif
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(bit rst, bit rd, logic [63:0] rpc, bit hl, bit rdy);
        bit pop;
        bit oob;
        bit fetch;
        if (rst) begin
            m_pc      = 64'd0;
            m_q.delete();
            m_halted  = 1'b0;
            m_faulted = 1'b0;
            return;
        end
        pop = (m_q.size() != 0) && rdy;
        if (rd) begin
            m_q.delete();
            m_pc      = norm_pc(rpc);
            m_halted  = hl;
            m_faulted = 1'b0;
            return;
        end
`ifdef FETCH_BOUNDS_CHECK_EN
        oob = (m_pc + 3 >= 64'(MEM_BYTES)) || (m_pc > 64'hFFFF_FFFF_FFFF_FFF0);
`else
        oob = 1'b0;
`endif
        fetch = !m_halted && !m_faulted && !hl && !oob &&
                ((m_q.size() < QDEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (fetch) begin
            m_q.push_back(m_pc);
            m_pc = next_pc(m_pc);
        end
        if (m_halted) begin
            m_halted = hl;
        end else if (!m_faulted) begin
            if (hl) m_halted = 1'b1;
            else if (oob) m_faulted = 1'b1;
        end
    endtask

    task automatic check_all();
        check("q_count", 64'(q_count), 64'(m_q.size()));
        check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        check("imem_addr", imem_addr, m_pc);
        check("fault", 64'(fault), 64'(m_faulted));
        if (m_q.size() != 0) begin
            check("out_pc", out_pc, m_q[0]);
            check("out_instr", 64'(out_instr), 64'(mem_word(m_q[0])));
        end
    endtask

    task automatic step(bit rst, bit rd, logic [63:0] rpc, bit hl, bit rdy);
        reset          = rst;
        redirect_valid = rd;
        redirect_pc    = rpc;
        halt           = hl;
        out_ready      = rdy;
        @(posedge clk);
        #1;
        model_update(rst, rd, rpc, hl, rdy);
        check_all();
    endtask

    initial begin
        bit          saw_wrap;
        logic [63:0] prev_pc;
        logic [63:0] rpc;

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        halt = 1'b0; out_ready = 1'b0;

        // Reset overrides redirect, halt and a pending dequeue.
        step(1, 1, 64'h200, 1, 1);
        step(1, 1, 64'h300, 1, 1);
        check("reset_pc", imem_addr, 64'd0);
        check("reset_count", 64'(q_count), 64'd0);

        // Streaming: one instruction per cycle.
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);

        // Backpressure saturates the queue at 4 entries with PC at 16.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
        check("sat_count", 64'(q_count), 64'd4);
        check("sat_pc", imem_addr, 64'd16);
        // Full plus pop: push and pop together.
        step(0, 0, 0, 0, 1);
        check("full_pop_count", 64'(q_count), 64'd4);
        check("full_pop_head", out_pc, 64'd4);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);

        // Redirect with 3 queued flushes and aligns the target.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        check("pre_redirect_count", 64'(q_count), 64'd3);
        step(0, 1, 64'h43, 0, 1);
        check("flush_count", 64'(q_count), 64'd0);
        check("redirect_addr", imem_addr, 64'h40);
        step(0, 0, 0, 0, 1);
        check("redirect_head", out_pc, 64'h40);

        // Halt drains the queue, freezes PC, then resumes there.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
        check("halt_drained", 64'(out_valid), 64'd0);
        check("halt_pc", imem_addr, 64'd8);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        check("resume_head", out_pc, 64'd8);
        // Redirect while halted: PC moves, queue flushes, no fetch.
        step(0, 1, 64'h101, 1, 0);
        step(0, 0, 0, 1, 0);
        check("halt_redirect_pc", imem_addr, 64'h100);
        check("halt_redirect_count", 64'(q_count), 64'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

        // Run off the end of memory.
        saw_wrap = 1'b0;
        prev_pc  = '1;
        step(0, 1, 64'd1008, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 1);
            if (out_valid) begin
                if (prev_pc == 64'd1020 && out_pc == 64'd0) saw_wrap = 1'b1;
                prev_pc = out_pc;
            end
        end
`ifdef FETCH_BOUNDS_CHECK_EN
        check("bounds_fault", 64'(fault), 64'd1);
        check("bounds_pc", imem_addr, 64'd1024);
        check("bounds_last", prev_pc, 64'd1020);
        step(0, 1, 64'd0, 0, 1);
        check("bounds_clear", 64'(fault), 64'd0);
`else
        check("wrap_seen", 64'(saw_wrap), 64'd1);
        check("wrap_fault", 64'(fault), 64'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 1) == 1) rpc = {$urandom, $urandom};
            else rpc = 64'($urandom_range(0, MEM_BYTES - 1));
            step(0, ($urandom_range(0, 15) == 0), rpc,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, instruction memory size in bytes (power of two, >4).
REQ-002 SHALL have parameter QDEPTH, default 4, fetch queue entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, word-aligned byte address fetched first after reset.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port imem_addr  output  64  byte address to instruction memory, always word-aligned.
REQ-007 SHALL have port imem_instr  input  32  combinational instruction for imem_addr, same cycle.
REQ-008 SHALL have port redirect_valid  input  1  branch/flush request.
REQ-009 SHALL have port redirect_pc  input  64  new fetch byte address; bits [1:0] ignored (treated as 0).
REQ-010 SHALL have port halt  input  1  while high, no new enqueues; queue still drains.
REQ-011 SHALL have port out_valid  output  1  queue head valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head.
REQ-013 SHALL have port out_instr  output  32  head instruction.
REQ-014 SHALL have port out_pc  output  64  head byte address.
REQ-015 SHALL have port q_count  output  $clog2(QDEPTH)+1  current queue occupancy.
REQ-016 SHALL have port fault  output  1  fetch stopped on out-of-bounds PC.

Function
REQ-017 SHALL hold PC register; imem_addr = PC combinationally.
REQ-018 SHALL be a state machine with states RUN, HALTED, FAULT.
REQ-019 RUN -> HALTED when halt=1; HALTED -> RUN when halt=0; any state -> RUN on redirect_valid (unless halt=1, then -> HALTED).
REQ-020 Enqueue SHALL occur in RUN with halt=0 and redirect_valid=0 when q_count<QDEPTH or a dequeue happens same cycle (full plus simultaneous pop is an enqueue).
REQ-021 Enqueue SHALL write {PC, imem_instr} at tail and set PC=PC+4 next cycle; PC unchanged when no enqueue.
REQ-022 Dequeue SHALL occur when out_valid=1 and out_ready=1; head advances next cycle.
REQ-023 Fetch latency: instruction at PC visible on out_instr one cycle after enqueue when queue was empty.
REQ-024 out_valid SHALL equal (q_count!=0); out_instr/out_pc SHALL be head entry, don't-care when empty.
REQ-025 redirect_valid SHALL have priority over all: queue flushed (q_count=0 next cycle), any same-cycle dequeue discarded, no enqueue that cycle, PC=redirect_pc with [1:0]=0.
REQ-026 Queue pointers SHALL wrap modulo QDEPTH; q_count SHALL never exceed QDEPTH nor underflow.
REQ-027 halt SHALL not block dequeues or redirects; redirect during halt updates PC, flushes, stays HALTED.

Reset
REQ-028 reset SHALL set PC=RESET_PC, q_count=0, out_valid=0, state=RUN, fault=0, pointers=0.
REQ-029 reset SHALL override redirect_valid, halt, and in-flight dequeue in the same cycle.
REQ-030 First enqueue SHALL occur in the first cycle after reset deasserts (if halt=0).

Configuration
REQ-031 With FETCH_BOUNDS_CHECK_EN defined: when in RUN and PC+3 >= MEM_BYTES, no enqueue, state -> FAULT, fault=1 from next cycle until redirect_valid to an in-bounds PC or reset; queue still drains in FAULT.
REQ-032 Without FETCH_BOUNDS_CHECK_EN: fault tied 0, FAULT state unreachable, PC+4 wraps modulo MEM_BYTES (MEM_BYTES-4 -> 0), redirect_pc reduced modulo MEM_BYTES.

Verification
REQ-033 Reset, halt=0, out_ready=1, memory word i = i -> out_pc 0,4,8,... with out_instr 0,1,2,... one per cycle from cycle 2.
REQ-034 out_ready=0 for 10 cycles -> q_count saturates at 4, PC stops at 16; then out_ready=1 -> pcs 0,4,8,12,16 in order, no loss or duplicate.
REQ-035 Queue full, out_ready=1 same cycle -> pop and push together, q_count stays 4.
REQ-036 redirect_valid with redirect_pc=0x43 while queue holds 3 -> q_count=0 next cycle, next out_pc=0x40, no stale entries.
REQ-037 halt=1 with 2 queued, out_ready=1 -> both drain, then out_valid=0, PC frozen; halt=0 -> fetch resumes at frozen PC.
REQ-038 Sequential run to PC=1020: with macro, 1020 enqueued, fault=1 after PC=1024, redirect to 0 clears fault; without macro, out_pc 1020 then 0.
